sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 26 ++
 rtl/sdram_refresh_timer.sv | 43 ++++
 rtl/sdram_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM arbiter slice.
// Contents:
//   sdram_cmd_e - 3-bit SDRAM command encodings {RAS_n, CAS_n, WE_n}
//   arb_state_e - arbiter FSM states
package sdram_arbiter_pkg;

  typedef enum logic [2:0] {
    CMD_NOP          = 3'b111,
    CMD_ACT          = 3'b011,
    CMD_READ         = 3'b101,
    CMD_WRITE        = 3'b100,
    CMD_TERM         = 3'b110,
    CMD_PRE          = 3'b010,
    CMD_AUTO_REFRESH = 3'b001
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT_WR,
    S_GRANT_RD,
    S_REFRESH_DRAIN,
    S_REFRESH_CMD,
    S_REFRESH_WAIT
  } arb_state_e;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval timer.
// Counts down from REFRESH_PERIOD-1 while init_done is high; at zero it
// raises pending and reloads in the same cycle. Expiry while pending is
// still set latches the sticky missed flag until reset.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   init_done  - counting enabled only once SDRAM init has completed
//   clear      - refresh command issued, drop pending
//   pending    - a refresh is due
//   missed     - sticky: an interval expired with a refresh still pending
module sdram_refresh_timer #(
  parameter int unsigned REFRESH_PERIOD = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  input  logic clear,
  output logic pending,
  output logic missed
);

  localparam int unsigned CW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= RELOAD;
      pending <= 1'b0;
      missed  <= 1'b0;
    end else if (init_done && count == '0) begin
      // A fresh expiry takes precedence over a same-cycle clear.
      count   <= RELOAD;
      pending <= 1'b1;
      if (pending) missed <= 1'b1;
    end else begin
      if (init_done) count <= count - CW'(1);
      if (clear) pending <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbiter sharing one SDRAM command bus between a write engine and a read
// engine, with periodic auto-refresh insertion.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   init_done                      - SDRAM power-up init complete
//   wr_req/rd_req                  - engine has work
//   wr_idle/rd_idle                - engine in idle/wait state
//   wr_/rd_command,address,bank    - engine-side SDRAM bus
//   wr_enable/rd_enable            - grants (mutually exclusive)
//   auto_refresh                   - refresh pending, engines wind down
//   command/address/bank           - registered shared SDRAM bus
//   refresh_missed                 - sticky missed-refresh flag
// Build option: define SDRAM_ARB_ROUND_ROBIN_EN to alternate the winner
// when both engines request in IDLE (write first after reset); otherwise
// write always beats read.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned T_RFC          = 7,
  parameter int unsigned MIN_GRANT      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        wr_idle,
  input  logic        rd_idle,
  input  logic [2:0]  wr_command,
  input  logic [2:0]  rd_command,
  input  logic [11:0] wr_address,
  input  logic [11:0] rd_address,
  input  logic [1:0]  wr_bank,
  input  logic [1:0]  rd_bank,
  output logic        wr_enable,
  output logic        rd_enable,
  output logic        auto_refresh,
  output logic [2:0]  command,
  output logic [11:0] address,
  output logic [1:0]  bank,
  output logic        refresh_missed
);

  localparam int unsigned GW = (MIN_GRANT > 1) ? $clog2(MIN_GRANT + 1) : 1;
  localparam int unsigned WW = (T_RFC > 1) ? $clog2(T_RFC + 1) : 1;

  arb_state_e    state, state_next;
  logic          refresh_pending;
  logic [GW-1:0] held;
  logic          min_met;
  logic [WW-1:0] wait_cnt;
  logic [2:0]    cmd_next;
  logic [11:0]   addr_next;
  logic [1:0]    bank_next;

  sdram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_refresh_timer (
    .clk      (clk),
    .rst      (rst),
    .init_done(init_done),
    .clear    (state == S_REFRESH_CMD),
    .pending  (refresh_pending),
    .missed   (refresh_missed)
  );

  // held counts completed grant cycles minus one; saturates once the
  // minimum hold time is satisfied.
  assign min_met = (held >= GW'(MIN_GRANT - 1));

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic last_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b0;
    end else if (state == S_IDLE && state_next == S_GRANT_WR) begin
      last_wr <= 1'b1;
    end else if (state == S_IDLE && state_next == S_GRANT_RD) begin
      last_wr <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      held     <= '0;
      wait_cnt <= '0;
      command  <= CMD_NOP;
      address  <= '0;
      bank     <= '0;
    end else begin
      state   <= state_next;
      command <= cmd_next;
      address <= addr_next;
      bank    <= bank_next;
      if (state_next != state) held <= '0;
      else if (!min_met)       held <= held + GW'(1);
      if (state == S_REFRESH_CMD)                         wait_cnt <= WW'(T_RFC - 1);
      else if (state == S_REFRESH_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (refresh_pending) begin
          state_next = S_REFRESH_DRAIN;
        end else if (init_done) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
          if (wr_req && (!rd_req || !last_wr)) state_next = S_GRANT_WR;
          else if (rd_req)                     state_next = S_GRANT_RD;
`else
          if (wr_req)      state_next = S_GRANT_WR;
          else if (rd_req) state_next = S_GRANT_RD;
`endif
        end
      end
      S_GRANT_WR: begin
        if (min_met && wr_idle) begin
          if (refresh_pending) state_next = S_REFRESH_DRAIN;
          else if (!wr_req)    state_next = S_IDLE;
        end
      end
      S_GRANT_RD: begin
        if (min_met && rd_idle) begin
          if (refresh_pending) state_next = S_REFRESH_DRAIN;
          else if (!rd_req)    state_next = S_IDLE;
        end
      end
      S_REFRESH_DRAIN: if (wr_idle && rd_idle) state_next = S_REFRESH_CMD;
      S_REFRESH_CMD:   state_next = S_REFRESH_WAIT;
      S_REFRESH_WAIT:  if (wait_cnt == '0) state_next = S_IDLE;
      default:         state_next = S_IDLE;
    endcase
  end

  // The AUTO_REFRESH is loaded on entry so it appears on the bus exactly
  // during the single REFRESH_CMD cycle.
  always_comb begin
    cmd_next  = CMD_NOP;
    addr_next = '0;
    bank_next = '0;
    case (state)
      S_GRANT_WR: begin
        cmd_next  = wr_command;
        addr_next = wr_address;
        bank_next = wr_bank;
      end
      S_GRANT_RD: begin
        cmd_next  = rd_command;
        addr_next = rd_address;
        bank_next = rd_bank;
      end
      default: ;
    endcase
    if (state_next == S_REFRESH_CMD) cmd_next = CMD_AUTO_REFRESH;
  end

  assign wr_enable    = (state == S_GRANT_WR);
  assign rd_enable    = (state == S_GRANT_RD);
  assign auto_refresh = refresh_pending;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  import sdram_arbiter_pkg::*;

  localparam int P    = 780;
  localparam int TRFC = 7;
  localparam int MG   = 2;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, init_done, wr_req, rd_req, wr_idle, rd_idle;
  logic [2:0]  wr_command, rd_command;
  logic [11:0] wr_address, rd_address;
  logic [1:0]  wr_bank, rd_bank;
  logic        wr_enable, rd_enable, auto_refresh, refresh_missed;
  logic [2:0]  command;
  logic [11:0] address;
  logic [1:0]  bank;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .REFRESH_PERIOD(P),
    .T_RFC(TRFC),
    .MIN_GRANT(MG)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .rd_req(rd_req), .wr_idle(wr_idle), .rd_idle(rd_idle),
    .wr_command(wr_command), .rd_command(rd_command),
    .wr_address(wr_address), .rd_address(rd_address),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .wr_enable(wr_enable), .rd_enable(rd_enable), .auto_refresh(auto_refresh),
    .command(command), .address(address), .bank(bank),
    .refresh_missed(refresh_missed)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: owner of the bus, refresh phase flags and a
  // plain count of init_done cycles for the refresh interval.
  int         m_n;
  bit         m_pending, m_missed;
  int         m_owner;      // 0 none, 1 write, 2 read
  int         m_held;
  bit         m_drain, m_in_cmd;
  int         m_rfc;
  bit         m_last_wr;
  logic [2:0]  m_command;
  logic [11:0] m_addr;
  logic [1:0]  m_bank;

  task automatic model_edge();
    int  owner_o;
    bit  pend_o, cmd_o, enter_cmd, expire, my_idle, my_req;
    int  pick;
    if (rst) begin
      m_n = 0; m_pending = 0; m_missed = 0; m_owner = 0; m_held = 0;
      m_drain = 0; m_in_cmd = 0; m_rfc = 0; m_last_wr = 0;
      m_command = CMD_NOP; m_addr = '0; m_bank = '0;
      return;
    end
    owner_o = m_owner; pend_o = m_pending; cmd_o = m_in_cmd; enter_cmd = 0;
    if (owner_o == 1)      begin m_command = wr_command; m_addr = wr_address; m_bank = wr_bank; end
    else if (owner_o == 2) begin m_command = rd_command; m_addr = rd_address; m_bank = rd_bank; end
    else                   begin m_command = CMD_NOP;    m_addr = '0;         m_bank = '0;     end

    if (m_in_cmd) begin
      m_in_cmd = 0; m_rfc = TRFC;
    end else if (m_rfc > 0) begin
      m_rfc--;
    end else if (m_drain) begin
      if (wr_idle && rd_idle) begin m_drain = 0; m_in_cmd = 1; enter_cmd = 1; end
    end else if (m_owner != 0) begin
      my_idle = (m_owner == 1) ? wr_idle : rd_idle;
      my_req  = (m_owner == 1) ? wr_req  : rd_req;
      if (m_held + 1 >= MG && my_idle) begin
        if (pend_o)       begin m_owner = 0; m_drain = 1; end
        else if (!my_req) m_owner = 0;
      end
      m_held++;
    end else if (pend_o) begin
      m_drain = 1;
    end else if (init_done) begin
      pick = 0;
      if (wr_req && rd_req) pick = (RR && m_last_wr) ? 2 : 1;
      else if (wr_req)      pick = 1;
      else if (rd_req)      pick = 2;
      if (pick != 0) begin m_owner = pick; m_held = 0; m_last_wr = (pick == 1); end
    end
    if (enter_cmd) m_command = CMD_AUTO_REFRESH;

    expire = init_done && (((m_n + 1) % P) == 0);
    if (init_done) m_n++;
    if (expire) begin
      if (pend_o) m_missed = 1;
      m_pending = 1;
    end else if (cmd_o) begin
      m_pending = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("wr_enable",      32'(wr_enable),      32'(m_owner == 1));
    check("rd_enable",      32'(rd_enable),      32'(m_owner == 2));
    check("auto_refresh",   32'(auto_refresh),   32'(m_pending));
    check("refresh_missed", 32'(refresh_missed), 32'(m_missed));
    check("command",        32'(command),        32'(m_command));
    check("address",        32'(address),        32'(m_addr));
    check("bank",           32'(bank),           32'(m_bank));
  endtask

  task automatic quiet_inputs();
    wr_req = 0; rd_req = 0; wr_idle = 1; rd_idle = 1;
    wr_command = CMD_NOP; rd_command = CMD_NOP;
    wr_address = '0; rd_address = '0; wr_bank = '0; rd_bank = '0;
  endtask

  task automatic do_reset(input logic init);
    quiet_inputs();
    init_done = init;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  typedef struct {
    bit wr, rd, wi, ri;
    int src;          // expected bus source: 0 none, 1 write, 2 read
    bit exp_wr_en, exp_rd_en;
  } vec_t;

  vec_t tbl[11];
  int   ar_idx[$];
  bit   seen;

  initial begin
    rst = 1; init_done = 0;
    quiet_inputs();

    // Reset state.
    do_reset(1'b1);
    check("reset_command", 32'(command), 32'(CMD_NOP));
    check("reset_enables", 32'({wr_enable, rd_enable}), 32'(0));
    check("reset_auto_refresh", 32'(auto_refresh), 32'(0));

    // Arbitration / hold / release table, applied from IDLE.
    tbl[0]  = '{1,1,0,1, 0, 1,0};
    tbl[1]  = '{1,1,1,1, 1, 1,0};
    tbl[2]  = '{0,1,1,1, 1, 0,0};
    tbl[3]  = '{0,1,1,0, 0, 0,1};
    tbl[4]  = '{0,1,1,1, 2, 0,1};
    tbl[5]  = '{0,0,1,1, 2, 0,0};
    tbl[6]  = '{1,1,1,1, 0, 1,0};
    tbl[7]  = '{1,1,1,1, 1, 1,0};
    tbl[8]  = '{0,1,1,1, 1, 0,0};
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    tbl[9]  = '{1,1,1,1, 0, 0,1};
    tbl[10] = '{1,1,0,0, 2, 0,1};
`else
    tbl[9]  = '{1,1,1,1, 0, 1,0};
    tbl[10] = '{1,1,0,0, 1, 1,0};
`endif
    for (int i = 0; i < 11; i++) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd; wr_idle = tbl[i].wi; rd_idle = tbl[i].ri;
      wr_command = CMD_WRITE; rd_command = CMD_READ;
      wr_address = 12'h100 + 12'(i); rd_address = 12'h200 + 12'(i);
      wr_bank = 2'd1; rd_bank = 2'd2;
      step();
      check("tbl_wr_enable", 32'(wr_enable), 32'(tbl[i].exp_wr_en));
      check("tbl_rd_enable", 32'(rd_enable), 32'(tbl[i].exp_rd_en));
      case (tbl[i].src)
        1:       check("tbl_bus", 32'({command, address, bank}), 32'({CMD_WRITE, 12'h100 + 12'(i), 2'd1}));
        2:       check("tbl_bus", 32'({command, address, bank}), 32'({CMD_READ,  12'h200 + 12'(i), 2'd2}));
        default: check("tbl_bus", 32'({command, address, bank}), 32'({CMD_NOP, 12'h000, 2'd0}));
      endcase
    end

    // No grant and no refresh before init_done.
    do_reset(1'b0);
    wr_req = 1;
    for (int i = 0; i < 1000; i++) begin
      step();
      check("preinit_wr_enable", 32'(wr_enable), 32'(0));
      check("preinit_no_refresh", 32'(command == CMD_AUTO_REFRESH), 32'(0));
    end

    // Idle refresh cadence.
    do_reset(1'b1);
    ar_idx.delete();
    for (int i = 0; i < 2400; i++) begin
      step();
      if (command == CMD_AUTO_REFRESH) ar_idx.push_back(i);
    end
    check("refresh_count", 32'(ar_idx.size()), 32'(3));
    for (int i = 1; i < ar_idx.size(); i++)
      check("refresh_interval", 32'(ar_idx[i] - ar_idx[i-1]), 32'(P));
    check("idle_refresh_missed", 32'(refresh_missed), 32'(0));

    // Refresh expiring during a write grant with the engine busy.
    do_reset(1'b1);
    wr_req = 1; wr_idle = 0; rd_req = 1; rd_idle = 1;
    seen = 0;
    for (int i = 0; i < 900 && !seen; i++) begin
      step();
      check("grant_rd_enable", 32'(rd_enable), 32'(0));
      seen = auto_refresh;
    end
    check("refresh_pending_seen", 32'(seen), 32'(1));
    for (int i = 0; i < 20; i++) begin
      step();
      check("busy_wr_held", 32'(wr_enable), 32'(1));
      check("busy_no_refresh", 32'(command == CMD_AUTO_REFRESH), 32'(0));
      check("busy_rd_enable", 32'(rd_enable), 32'(0));
    end
    wr_idle = 1; wr_req = 0;
    step();
    check("drain_no_refresh_yet", 32'(command == CMD_AUTO_REFRESH), 32'(0));
    check("drain_wr_released", 32'(wr_enable), 32'(0));
    step();
    check("drain_refresh_issued", 32'(command), 32'(CMD_AUTO_REFRESH));
    check("drain_rd_enable", 32'(rd_enable), 32'(0));
    for (int i = 0; i < TRFC; i++) begin
      step();
      check("rfc_nop", 32'(command), 32'(CMD_NOP));
      check("rfc_rd_enable", 32'(rd_enable), 32'(0));
    end

    // Engine busy across two intervals -> sticky missed flag.
    do_reset(1'b1);
    wr_req = 1; wr_idle = 0;
    for (int i = 0; i < 1600; i++) step();
    check("missed_set", 32'(refresh_missed), 32'(1));
    wr_idle = 1; wr_req = 0;
    for (int i = 0; i < 50; i++) step();
    check("missed_sticky", 32'(refresh_missed), 32'(1));
    rst = 1;
    step();
    rst = 0;
    check("missed_cleared_by_rst", 32'(refresh_missed), 32'(0));

    // Reset in the middle of a grant.
    do_reset(1'b1);
    wr_req = 1; wr_idle = 0; wr_command = CMD_WRITE;
    step(); step(); step();
    check("midgrant_wr_enable", 32'(wr_enable), 32'(1));
    rst = 1;
    step();
    check("midrst_enables", 32'({wr_enable, rd_enable}), 32'(0));
    check("midrst_command", 32'(command), 32'(CMD_NOP));
    rst = 0; wr_req = 0; rd_req = 1; rd_idle = 0;
    step();
    check("midrst_back_in_idle", 32'(rd_enable), 32'(1));

    // Randomised traffic against the reference model.
    do_reset(1'b1);
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 999) == 0);
      init_done  = ($urandom_range(0, 49) != 0);
      wr_req     = ($urandom_range(0, 9) < 4);
      rd_req     = ($urandom_range(0, 9) < 4);
      wr_idle    = ($urandom_range(0, 9) < 7);
      rd_idle    = ($urandom_range(0, 9) < 7);
      wr_command = 3'($urandom);
      rd_command = 3'($urandom);
      wr_address = 12'($urandom);
      rd_address = 12'($urandom);
      wr_bank    = 2'($urandom);
      rd_bank    = 2'($urandom);
      step();
      check("one_hot_grant", 32'(wr_enable & rd_enable), 32'(0));
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
